// File: rtl/dram_model_pkg.sv
// Shared definitions for the multiplexed-address DRAM model: FSM state
// encoding and the mapping from (row, col) to the flat storage index.
package dram_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_HOLD = 3'd3,
    ST_CBR  = 3'd4
  } state_e;

  // Storage is organised as {col, row}; the caller narrows the result to
  // ROW_W+COL_W bits.
  function automatic int unsigned dram_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned row_w);
    return (col << row_w) | row;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency delay line: carries the read strobe and the word fetched at
// the CAS-fall edge through RD_LATENCY register stages.
module dram_rd_pipe
  import dram_model_pkg::*;
#(
  parameter int DW         = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [DW-1:0]         data_q [RD_LATENCY];

  // Shift valid and data one stage per clock; reset empties the pipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LATENCY-1];
  assign data_o = data_q[RD_LATENCY-1];

endmodule

// File: rtl/dram_mux_model.sv
// Parametrised multiplexed-address DRAM model. Decodes RAS/CAS edges,
// supports early/late write, fast-page mode, CBR and RAS-only refresh
// counting, a configurable read latency and a sticky protocol-error flag.
module dram_mux_model
  import dram_model_pkg::*;
#(
  parameter int    DW         = 4,
  parameter int    ADDR_W     = 8,
  parameter int    ROW_W      = 8,
  parameter int    COL_W      = 6,
  parameter int    COL_LSB    = 1,
  parameter int    PAGE_MODE  = 1,
  parameter int    RD_LATENCY = 1,
  parameter int    REF_W      = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic              i_MCLK,
  input  logic              i_RST_n,
  input  logic [ADDR_W-1:0] i_ADDR,
  input  logic [DW-1:0]     i_DIN,
  output logic [DW-1:0]     o_DOUT,
  output logic              o_DOUT_VLD,
  input  logic              i_RAS_n,
  input  logic              i_CAS_n,
  input  logic              i_WR_n,
  input  logic              i_OE_n,
  output logic [REF_W-1:0]  o_REFRESH_CNT,
  output logic              o_ERR
);

  localparam int IDX_W = ROW_W + COL_W;
  localparam int DEPTH = 1 << IDX_W;

  // Contents are never reset; when INIT_FILE is set the array is preloaded
  // by the memory-initialisation flow of the target toolchain.
  if (INIT_FILE != "") begin : g_init_hook
  end

  logic [DW-1:0]    mem [DEPTH];

  logic             ras_q, cas_q;
  logic             ras_fall, ras_rise, cas_fall, cas_rise;
  state_e           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             cas_seen_q, rd_issued_q, late_done_q;
  logic [REF_W-1:0] ref_cnt_q;
  logic             err_q;

  logic [ROW_W-1:0] row_in;
  logic [COL_W-1:0] col_in;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_en, wr_en, late_wr;
  logic [DW-1:0]    rd_data;

  logic             pipe_vld;
  logic [DW-1:0]    pipe_data;
  logic [DW-1:0]    dout_q;
  logic             dout_vld_q;

  assign row_in = i_ADDR[ROW_W-1:0];
  assign col_in = i_ADDR[COL_LSB +: COL_W];

  assign ras_fall = ras_q & ~i_RAS_n;
  assign ras_rise = ~ras_q & i_RAS_n;
  assign cas_fall = cas_q & ~i_CAS_n;
  assign cas_rise = ~cas_q & i_CAS_n;

  // Previous strobe levels for edge detection; idle level is high.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      ras_q <= 1'b1;
      cas_q <= 1'b1;
    end else begin
      ras_q <= i_RAS_n;
      cas_q <= i_CAS_n;
    end
  end

  // Decode which memory access (if any) happens on this edge; a RAS rise
  // always wins over a coincident CAS event.
  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    late_wr = 1'b0;
    rd_idx  = IDX_W'(dram_index(32'(row_q), 32'(col_in), ROW_W));
    wr_idx  = IDX_W'(dram_index(32'(row_q), 32'(col_in), ROW_W));
    case (state_q)
      ST_ROW: begin
        if (cas_fall && !ras_rise) begin
          if (!i_WR_n) wr_en = 1'b1;
          else         rd_en = 1'b1;
        end
      end
      ST_COL: begin
        if (!ras_rise && !i_CAS_n && rd_issued_q && !late_done_q && !i_WR_n) begin
          late_wr = 1'b1;
          wr_en   = 1'b1;
          wr_idx  = IDX_W'(dram_index(32'(row_q), 32'(col_q), ROW_W));
        end
      end
      default: ;
    endcase
  end

  // Storage write port; the read for the same edge sees the old word.
  always_ff @(posedge i_MCLK) begin
    if (wr_en) mem[wr_idx] <= i_DIN;
  end

  assign rd_data = mem[rd_idx];

  // Access FSM with registered refresh counter and sticky error flag.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cas_seen_q  <= 1'b0;
      rd_issued_q <= 1'b0;
      late_done_q <= 1'b0;
      ref_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ras_fall) begin
            if (i_CAS_n) begin
              row_q      <= row_in;
              cas_seen_q <= 1'b0;
              state_q    <= ST_ROW;
            end else begin
              ref_cnt_q <= ref_cnt_q + 1'b1;
              state_q   <= ST_CBR;
            end
          end
        end
        ST_ROW: begin
          if (ras_rise) begin
            if (!cas_seen_q) ref_cnt_q <= ref_cnt_q + 1'b1;
            state_q <= ST_IDLE;
          end else if (cas_fall) begin
            col_q       <= col_in;
            cas_seen_q  <= 1'b1;
            rd_issued_q <= i_WR_n;
            late_done_q <= 1'b0;
            state_q     <= ST_COL;
          end
        end
        ST_COL: begin
          if (ras_rise) begin
            state_q <= ST_IDLE;
          end else if (cas_rise) begin
            state_q <= (PAGE_MODE != 0) ? ST_ROW : ST_HOLD;
          end else if (late_wr) begin
            late_done_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (ras_rise)      state_q <= ST_IDLE;
          else if (cas_fall) err_q   <= 1'b1;
        end
        ST_CBR: begin
          if (ras_rise) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dram_rd_pipe #(
    .DW         (DW),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk_i  (i_MCLK),
    .rst_ni (i_RST_n),
    .vld_i  (rd_en),
    .data_i (rd_data),
    .vld_o  (pipe_vld),
    .data_o (pipe_data)
  );

  // Output register: updated only when the pipe delivers and OE is low.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (pipe_vld && !i_OE_n) begin
      dout_q     <= pipe_data;
      dout_vld_q <= 1'b1;
    end else begin
      dout_vld_q <= 1'b0;
    end
  end

  assign o_DOUT        = dout_q;
  assign o_DOUT_VLD    = dout_vld_q;
  assign o_REFRESH_CNT = ref_cnt_q;
  assign o_ERR         = err_q;

endmodule

// File: tb/tb_dram_mux_model.sv
// Scoreboard bench for dram_mux_model: a page-mode instance (checked via the
// read queue) and a PAGE_MODE=0 instance sharing the same stimulus.
module tb_dram_mux_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic [3:0] din;
  logic       ras_n, cas_n, wr_n, oe_n;

  logic [3:0] dout1, dout0;
  logic       vld1, vld0;
  logic [7:0] cnt1, cnt0;
  logic       err1, err0;

  int unsigned cyc_cnt = 0;
  int          n_chk   = 0;
  int          n_fail  = 0;

  typedef struct packed {
    logic [3:0]  data;
    logic [31:0] due;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  dram_mux_model u_dut (
    .i_MCLK(clk), .i_RST_n(rst_n), .i_ADDR(addr), .i_DIN(din),
    .o_DOUT(dout1), .o_DOUT_VLD(vld1), .i_RAS_n(ras_n), .i_CAS_n(cas_n),
    .i_WR_n(wr_n), .i_OE_n(oe_n), .o_REFRESH_CNT(cnt1), .o_ERR(err1)
  );

  dram_mux_model #(.PAGE_MODE(0)) u_dut_np (
    .i_MCLK(clk), .i_RST_n(rst_n), .i_ADDR(addr), .i_DIN(din),
    .o_DOUT(dout0), .o_DOUT_VLD(vld0), .i_RAS_n(ras_n), .i_CAS_n(cas_n),
    .i_WR_n(wr_n), .i_OE_n(oe_n), .o_REFRESH_CNT(cnt0), .o_ERR(err0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: every read pulse must match the head of the queue in data and cycle.
  always @(negedge clk) begin
    if (vld1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dout_unexpected: got pulse with %0h, expected no pulse", dout1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout_data", {28'h0, dout1}, {28'h0, e.data});
        chk("dout_cycle", cyc_cnt, e.due);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ras_lo(input logic [7:0] row);
    @(negedge clk);
    addr  = row;
    ras_n = 1'b0;
  endtask

  task automatic ras_hi();
    @(negedge clk);
    ras_n = 1'b1;
    @(negedge clk);
  endtask

  // One-clock CAS pulse; a read with OE low queues its expected word.
  task automatic cas_cyc(input logic [7:0] a, input logic wr, input logic [3:0] d,
                         input logic [3:0] exp);
    exp_t e;
    @(negedge clk);
    addr  = a;
    wr_n  = wr;
    din   = d;
    cas_n = 1'b0;
    if (wr && !oe_n) begin
      e.data = exp;
      e.due  = cyc_cnt + 2;
      q.push_back(e);
    end
    @(negedge clk);
    cas_n = 1'b1;
    wr_n  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ras_n = 1'b1; cas_n = 1'b1; wr_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cbr(input logic together);
    @(negedge clk);
    cas_n = 1'b0;
    if (!together) @(negedge clk);
    ras_n = 1'b0;
    @(negedge clk);
    ras_n = 1'b1;
    cas_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ras_n = 1'b1; cas_n = 1'b1; wr_n = 1'b1; oe_n = 1'b0;
    addr = '0; din = '0;
    idle(3);
    rst_n = 1'b1;

    // Reset values
    chk("rst_dout", {28'h0, dout1}, 32'h0);
    chk("rst_vld", {31'h0, vld1}, 32'h0);
    chk("rst_cnt", {24'h0, cnt1}, 32'h0);
    chk("rst_err", {31'h0, err1}, 32'h0);
    chk("rst_err_np", {31'h0, err0}, 32'h0);

    // Early write of 0xA to {0x25,0x35}, then read it back
    ras_lo(8'h35); cas_cyc(8'h4A, 1'b0, 4'hA, 4'h0); ras_hi();
    ras_lo(8'h35); cas_cyc(8'h4A, 1'b1, 4'h0, 4'hA); ras_hi();

    // Fast page: three writes then three reads in one RAS each
    ras_lo(8'h10);
    cas_cyc(8'h04, 1'b0, 4'h1, 4'h0);
    cas_cyc(8'h08, 1'b0, 4'h2, 4'h0);
    cas_cyc(8'h0C, 1'b0, 4'h3, 4'h0);
    ras_hi();
    ras_lo(8'h10);
    cas_cyc(8'h04, 1'b1, 4'h0, 4'h1);
    cas_cyc(8'h08, 1'b1, 4'h0, 4'h2);
    cas_cyc(8'h0C, 1'b1, 4'h0, 4'h3);
    ras_hi();
    idle(3);
    chk("page_err", {31'h0, err1}, 32'h0);
    chk("np_multi_cas_err", {31'h0, err0}, 32'h1);

    // Late write with OE high: {col 0x01, row 0x02} goes 0x5 -> 0xC
    ras_lo(8'h02); cas_cyc(8'h02, 1'b0, 4'h5, 4'h0); ras_hi();
    oe_n = 1'b1;
    ras_lo(8'h02);
    @(negedge clk); addr = 8'h02; wr_n = 1'b1; cas_n = 1'b0;
    @(negedge clk);
    @(negedge clk); wr_n = 1'b0; din = 4'hC;
    @(negedge clk); din = 4'hD;
    @(negedge clk); cas_n = 1'b1; wr_n = 1'b1;
    ras_hi();
    idle(2);
    chk("oe_hold", {28'h0, dout1}, 32'h3);
    oe_n = 1'b0;
    ras_lo(8'h02); cas_cyc(8'h02, 1'b1, 4'h0, 4'hC); ras_hi();

    // RAS rise together with a write CAS fall: no access
    ras_lo(8'h02);
    @(negedge clk); ras_n = 1'b1; cas_n = 1'b0; addr = 8'h02; wr_n = 1'b0; din = 4'h1;
    @(negedge clk); cas_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    ras_lo(8'h02); cas_cyc(8'h02, 1'b1, 4'h0, 4'hC); ras_hi();

    // Reset asserted in COL with write enable low
    ras_lo(8'h44); cas_cyc(8'h22, 1'b0, 4'h6, 4'h0); ras_hi();
    ras_lo(8'h44);
    @(negedge clk); addr = 8'h22; wr_n = 1'b1; cas_n = 1'b0;
    @(negedge clk); rst_n = 1'b0; wr_n = 1'b0; din = 4'h9;
    @(negedge clk);
    chk("midrst_dout", {28'h0, dout1}, 32'h0);
    chk("midrst_vld", {31'h0, vld1}, 32'h0);
    chk("midrst_cnt", {24'h0, cnt1}, 32'h0);
    chk("midrst_err", {31'h0, err1}, 32'h0);
    chk("midrst_err_np", {31'h0, err0}, 32'h0);
    ras_n = 1'b1; cas_n = 1'b1; wr_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    ras_lo(8'h44); cas_cyc(8'h22, 1'b1, 4'h0, 4'h6); ras_hi();

    // Refresh counting: CBR (separate), CBR (same edge), RAS-only
    do_reset();
    cbr(1'b0);
    cbr(1'b1);
    ras_lo(8'h7F); ras_hi();
    chk("ref_cnt3", {24'h0, cnt1}, 32'd3);
    chk("ref_cnt3_np", {24'h0, cnt0}, 32'd3);
    for (int i = 0; i < 252; i++) begin
      ras_lo(8'h7F); ras_hi();
    end
    chk("ref_cnt255", {24'h0, cnt1}, 32'd255);
    cbr(1'b0);
    chk("ref_wrap", {24'h0, cnt1}, 32'd0);
    chk("ref_wrap_np", {24'h0, cnt0}, 32'd0);

    // PAGE_MODE=0: second CAS in one RAS must not write and sets ERR
    do_reset();
    ras_lo(8'h20); cas_cyc(8'h0A, 1'b0, 4'h7, 4'h0); ras_hi();
    chk("np_single_cas_ok", {31'h0, err0}, 32'h0);
    oe_n = 1'b1;
    ras_lo(8'h20);
    cas_cyc(8'h0C, 1'b1, 4'h0, 4'h0);
    cas_cyc(8'h0A, 1'b0, 4'h9, 4'h0);
    ras_hi();
    oe_n = 1'b0;
    chk("np_err_set", {31'h0, err0}, 32'h1);
    chk("page_err_clear", {31'h0, err1}, 32'h0);
    idle(5);
    chk("np_err_sticky", {31'h0, err0}, 32'h1);
    ras_lo(8'h20); cas_cyc(8'h0A, 1'b1, 4'h0, 4'h9); ras_hi();
    idle(2);
    chk("np_no_write", {28'h0, dout0}, 32'h7);
    chk("np_err_still", {31'h0, err0}, 32'h1);
    do_reset();
    chk("np_err_rst", {31'h0, err0}, 32'h0);

    // Let outstanding reads drain
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_mux_model.md
Name: dram_mux_model

Overview:
- Parametrised multiplexed-address DRAM model; successor to the fixed 16k×4 4416 char-RAM models in the video core.
- Adds generic width/geometry, edge-based RAS/CAS decoding, early and late write, fast-page mode, CAS-before-RAS and RAS-only refresh counting, configurable read latency and a protocol-error flag.
- Sits between the video timing/CPU arbitration logic and the bus.
- Memory contents are simulation/BRAM-initialisable.

Parameters:
- DW, 4: data width.
- ADDR_W, 8: multiplexed address bus width.
- ROW_W, 8: row bits; row = i_ADDR[ROW_W-1:0], ROW_W ≤ ADDR_W.
- COL_W, 6: column bits; col = i_ADDR[COL_LSB+COL_W-1:COL_LSB].
- COL_LSB, 1: column slice offset in i_ADDR.
- PAGE_MODE, 1: 1 allows multiple CAS cycles per RAS; 0 allows one CAS cycle per RAS.
- RD_LATENCY, 1: cycles from CAS-fall sample to o_DOUT update (1..4).
- REF_W, 8: refresh counter width.
- INIT_FILE, "": hex init file; empty means no init.

Ports:
- i_MCLK, in, 1: clock; all inputs sampled on rising edge.
- i_RST_n, in, 1: asynchronous active-low reset.
- i_ADDR, in, ADDR_W: multiplexed row/column address.
- i_DIN, in, DW: write data.
- o_DOUT, out, DW: read data register.
- o_DOUT_VLD, out, 1: one-cycle pulse when o_DOUT is updated.
- i_RAS_n, in, 1: row strobe.
- i_CAS_n, in, 1: column strobe.
- i_WR_n, in, 1: write enable.
- i_OE_n, in, 1: output enable; gates the o_DOUT update.
- o_REFRESH_CNT, out, REF_W: count of refresh cycles.
- o_ERR, out, 1: sticky protocol-error flag.

Behaviour:
- Storage is 2^(ROW_W+COL_W) × DW words, index = {col, row}. Storage is never reset.
- Registered ras_q and cas_q reset to 1. ras_fall = ras_q & ~i_RAS_n; ras_rise = ~ras_q & i_RAS_n; likewise cas_fall and cas_rise.
- Reset values: o_DOUT = 0, o_DOUT_VLD = 0, o_REFRESH_CNT = 0, o_ERR = 0, row/col latches = 0, state IDLE, read pipe empty.
- Reset asserted mid-access aborts the access; no write occurs on the reset edge.
- FSM states: IDLE, ROW, COL, HOLD, CBR.
- IDLE:
  - ras_fall with i_CAS_n = 1: latch row, go to ROW, clear the cas_seen flag.
  - ras_fall with i_CAS_n = 0: go to CBR, increment o_REFRESH_CNT.
  - cas_fall alone: ignored.
- ROW:
  - cas_fall: latch col; go to COL; set cas_seen.
  - Same edge with i_WR_n = 0: early write of i_DIN to {col_new, row}.
  - Same edge with i_WR_n = 1: issue read of {col_new, row} into the read pipe.
  - ras_rise: go to IDLE. If cas_seen = 0, this was a RAS-only refresh: increment o_REFRESH_CNT.
- COL:
  - First cycle with i_WR_n = 0 while CAS is low after a read-issued CAS fall: late write, at most once per CAS cycle.
  - cas_rise: go to ROW if PAGE_MODE = 1, else go to HOLD.
  - ras_rise: go to IDLE.
- HOLD (PAGE_MODE = 0 only):
  - cas_fall: set o_ERR; no access.
  - ras_rise: go to IDLE.
- CBR: ras_rise goes to IDLE. No memory access.
- Simultaneous events:
  - ras_rise and cas_fall on the same edge: ras_rise wins; no access.
  - ras_fall and cas_fall on the same edge: treated as CBR.
- Read pipe:
  - RD_LATENCY-stage valid/data shift.
  - At pipe output, if i_OE_n = 0: o_DOUT ← data and o_DOUT_VLD = 1.
  - At pipe output, if i_OE_n = 1: o_DOUT holds.
  - A write to the same address on the read-issue edge returns the old data (read-before-write).
  - Reads issued on later edges see the written data.
- o_REFRESH_CNT wraps from all-ones to 0.
- o_ERR is cleared only by reset.

Decomposition:
- Package dram_model_pkg: FSM state encoding constants (IDLE = 0, ROW = 1, COL = 2, HOLD = 3, CBR = 4) and a function mapping (row, col) to the storage index.
- One sub-module, dram_rd_pipe: parameter DW and RD_LATENCY; valid/data delay line with asynchronous active-low reset.

Test Plan (all scenarios use default parameters):
- Early write then read:
  - Stimulus: row 0x35; CAS with i_ADDR 0x4A (col 0x25); i_WR_n = 0; i_DIN 0xA. New RAS; same address; i_WR_n = 1; i_OE_n = 0.
  - Required: storage[0x2535] = 0xA; o_DOUT = 0xA one cycle after the CAS-fall sample; o_DOUT_VLD pulses exactly once.
- Fast page:
  - Stimulus: row 0x10; three CAS cycles, i_ADDR 0x04/0x08/0x0C, writing 1/2/3; then one RAS with three read CAS cycles.
  - Required: o_DOUT sequence 1, 2, 3; three o_DOUT_VLD pulses; o_ERR = 0.
- PAGE_MODE = 0:
  - Stimulus: second CAS fall within the same RAS, i_WR_n = 0.
  - Required: no write occurs (target word unchanged); o_ERR = 1 and stays 1 until reset.
- Refresh counting:
  - Stimulus: 2 CBR cycles plus 1 RAS-only cycle, from reset.
  - Required: o_REFRESH_CNT = 3. Separately, preloading 255 RAS-only cycles then one CBR wraps the count to 0.
- Late write and OE gating:
  - Stimulus: read-CAS to {0x01, 0x02} holding old value 0x5; i_WR_n falls two cycles later with i_DIN 0xC; i_OE_n = 1 throughout.
  - Required: o_DOUT holds its old value with no o_DOUT_VLD pulse; a subsequent read of {0x01, 0x02} returns 0xC.
- Reset mid-access:
  - Stimulus: assert i_RST_n = 0 in COL with i_WR_n = 0.
  - Required: state returns to IDLE; all outputs reset to 0; target word unchanged; the next RAS/CAS access behaves normally.
